chu_rotary_enc_core: RTL
========================

// Module: chu_rotary_enc_core
// PURPOSE
//  MMIO slot core for the Pmod ENC rotary encoder on PMOD JA top row (A, B, BTN, SWT).
//  Synchronises and debounces the four pins, then decodes quadrature into a signed detent counter.
//  Latches button-press and overflow events, and exposes them through the FPro MMIO slot register interface.
//  Instantiated inside mmio_sys_sampler; driven by the MCS bridge through the slot bus.
// PARAMETERS
//  DB_CYCLES  50_000  cycles a synchronised input must stay stable before its filtered value updates (0.5 ms @100 MHz)
//  CNT_W      16      width of the signed detent counter (2..31)
// PORTS
//  clk      in   1   system clock, 100 MHz
//  reset    in   1   asynchronous, active-high reset
//  cs       in   1   slot select
//  read     in   1   read strobe (qualified by cs)
//  write    in   1   write strobe (qualified by cs)
//  addr     in   5   register index within slot
//  wr_data  in   32  write data
//  rd_data  out  32  read data, combinational from addr
//  enc_a    in   1   encoder channel A (ja_top[1]), asynchronous
//  enc_b    in   1   encoder channel B (ja_top[2]), asynchronous
//  enc_btn  in   1   push button (ja_top[3]), high = pressed
//  enc_swt  in   1   slide switch (ja_top[4])
// BEHAVIOUR
//  Reset values:
//   - count = 0; all sticky flags = 0; sat_en = 0; FSM = REST.
//   - Filtered A/B = 1 (encoder rest level 11); filtered btn/swt = 0.
//   - Sync and debounce stages load the same values as their filtered outputs.
//  Input conditioning, per pin:
//   - 2-FF synchroniser, then debounce counter.
//   - Counter clears whenever the synchronised value equals the filtered value.
//   - When the counter reaches DB_CYCLES-1 with the value still different, the filtered value flips and the counter clears.
//   - Pin-to-filtered latency = 2 + DB_CYCLES cycles.
//  Quadrature FSM, on filtered {A,B}:
//   - States: REST(11), CW1(01), CW2(00), CW3(10), CCW1(10), CCW2(00), CCW3(01).
//   - CW path: REST->CW1->CW2->CW3->REST gives count +1 on entering REST.
//   - CCW path: REST->CCW1->CCW2->CCW3->REST gives count -1 on entering REST.
//   - One-step backtrack moves to the previous state on the same path; no count.
//   - From CW1 or CCW1, AB=11 returns to REST with no count.
//   - Two-bit jump (illegal Gray transition): hold state, no count, no flag.
//   - Result: one count per full detent only.
//  Counter arithmetic, CNT_W-bit two's complement:
//   - sat_en=0: wraps (max+1 -> min, min-1 -> max); ovf_flag sets on wrap.
//   - sat_en=1: clamps at max/min; an attempted step beyond the limit sets ovf_flag; count unchanged.
//   - dir bit = 1 after a +1 step, 0 after a -1 step; reset 0.
//  Button press: btn_flag sets on filtered btn 0->1 edge (one event per debounced press).
//  Register map (addr[1:0]; addr[4:2] != 0 reads 0, writes ignored):
//   - 0 R: count, sign-extended to 32 bits.
//   - 1 R: {26'b0, ovf_flag, btn_flag, dir, swt, btn, 1'b0}; bit0 reserved 0.
//   - 2 W: bit0 clear count, bit1 clear btn_flag, bit2 clear ovf_flag. Write-1 pulses; reads 0.
//   - 3 R/W: bit0 sat_en.
//   - Reads have no side effects; writes take effect on the next clk edge.
//  Simultaneous events:
//   - Count clear and step on the same cycle: clear wins (count = 0).
//   - Flag clear and flag-setting event on the same cycle: set wins.
//  Reset mid-operation: all state returns to reset values immediately (async); partial rotation is discarded.
// TESTING (bench overrides DB_CYCLES=4, CNT_W=4)
//  1. Drive AB 11->01->00->10->11, each held 10 cycles -> reg0 = 1, status dir = 1.
//     Reverse sequence -> reg0 = 0, dir = 0.
//  2. Glitch A low for 3 cycles from rest -> FSM stays REST, reg0 unchanged.
//     Hold A low for 6 cycles -> filtered A updates 6 cycles after pin edge.
//  3. sat_en=0, 8 CW detents from 0 -> reg0 = 0xFFFF_FFF8 (-8), ovf_flag = 1.
//     sat_en=1, 9 CW detents from 0 -> reg0 = 7, ovf_flag = 1.
//  4. Partial CW (11->01->00) then back (00->01->11) -> reg0 unchanged.
//     Two-bit jump 11->00 -> no state change.
//  5. Press btn 10 cycles, release -> btn_flag = 1.
//     Write reg2 = 0x2 on the same cycle as a new debounced press -> btn_flag stays 1.
//  6. Assert reset during CW2 -> reg0 = 0, FSM REST, flags 0.
//     After release, a full CW detent counts exactly +1.

Source files
------------

// File: rtl/chu_rotary_enc_core_if.sv
// FPro MMIO slot bus between the bridge (master) and a slot core (slave).
// rd_data is combinational from addr on the slave side.
interface chu_rotary_enc_core_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output cs, read, write, addr, wr_data, input rd_data);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/chu_rotary_enc_core.sv
// Pmod ENC slot core: synchronise/debounce A, B, BTN, SWT, decode quadrature
// into a signed detent counter, and expose count/status/control over the slot bus.
module chu_rotary_enc_core #(
    parameter int DB_CYCLES = 50_000,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    chu_rotary_enc_core_if.slave   bus,
    input  logic                   enc_a,
    input  logic                   enc_b,
    input  logic                   enc_btn,
    input  logic                   enc_swt
);
    localparam int NPIN = 4;
    localparam int DBW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    // Pin order {swt, btn, b, a}; encoder rests at AB=11.
    localparam logic [NPIN-1:0] PIN_RST = 4'b0011;
    localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    logic [NPIN-1:0] pin_raw;
    logic [NPIN-1:0] filt;
    logic [NPIN-1:0] flip;

    assign pin_raw = {enc_swt, enc_btn, enc_b, enc_a};

    for (genvar i = 0; i < NPIN; i++) begin : g_pin
        logic           sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d, flip_c;
        logic [DBW-1:0] cnt_q, cnt_d;

        always_comb begin
            sync1_d = pin_raw[i];
            sync2_d = sync1_q;
            filt_d  = filt_q;
            cnt_d   = cnt_q;
            flip_c  = 1'b0;
            if (sync2_q == filt_q) begin
                cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
                filt_d = ~filt_q;
                cnt_d  = '0;
                flip_c = 1'b1;
            end else begin
                cnt_d = cnt_q + DBW'(1);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1_q <= PIN_RST[i];
                sync2_q <= PIN_RST[i];
                filt_q  <= PIN_RST[i];
                cnt_q   <= '0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                filt_q  <= filt_d;
                cnt_q   <= cnt_d;
            end
        end

        assign filt[i] = filt_q;
        assign flip[i] = flip_c;
    end

    // Quadrature decode: only a complete detent ending back at rest counts.
    typedef enum logic [2:0] {
        S_REST, S_CW1, S_CW2, S_CW3, S_CCW1, S_CCW2, S_CCW3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ab;
    logic       step_up, step_dn;

    assign ab = {filt[0], filt[1]};

    always_comb begin
        state_d = state_q;
        step_up = 1'b0;
        step_dn = 1'b0;
        case (state_q)
            S_REST: begin
                if (ab == 2'b01)      state_d = S_CW1;
                else if (ab == 2'b10) state_d = S_CCW1;
            end
            S_CW1: begin
                if (ab == 2'b00)      state_d = S_CW2;
                else if (ab == 2'b11) state_d = S_REST;
            end
            S_CW2: begin
                if (ab == 2'b10)      state_d = S_CW3;
                else if (ab == 2'b01) state_d = S_CW1;
            end
            S_CW3: begin
                if (ab == 2'b11) begin
                    state_d = S_REST;
                    step_up = 1'b1;
                end else if (ab == 2'b00) begin
                    state_d = S_CW2;
                end
            end
            S_CCW1: begin
                if (ab == 2'b00)      state_d = S_CCW2;
                else if (ab == 2'b11) state_d = S_REST;
            end
            S_CCW2: begin
                if (ab == 2'b01)      state_d = S_CCW3;
                else if (ab == 2'b10) state_d = S_CCW1;
            end
            S_CCW3: begin
                if (ab == 2'b11) begin
                    state_d = S_REST;
                    step_dn = 1'b1;
                end else if (ab == 2'b00) begin
                    state_d = S_CCW2;
                end
            end
            default: state_d = S_REST;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_REST;
        else       state_q <= state_d;
    end

    // Counter, flags and control register.
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d, btn_flag_q, btn_flag_d, dir_q, dir_d, sat_q, sat_d;
    logic             ovf_set, btn_rise;
    logic             wr_ok, wr_ctl, wr_cfg;

    assign wr_ok    = bus.cs & bus.write & (bus.addr[4:2] == 3'b000);
    assign wr_ctl   = wr_ok & (bus.addr[1:0] == 2'd2);
    assign wr_cfg   = wr_ok & (bus.addr[1:0] == 2'd3);
    assign btn_rise = flip[2] & ~filt[2];

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        sat_d   = sat_q;
        ovf_set = 1'b0;
        if (step_up) begin
            dir_d = 1'b1;
            if (count_q == CNT_MAX) begin
                ovf_set = 1'b1;
                count_d = sat_q ? count_q : CNT_MIN;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (step_dn) begin
            dir_d = 1'b0;
            if (count_q == CNT_MIN) begin
                ovf_set = 1'b1;
                count_d = sat_q ? count_q : CNT_MAX;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
        // Clear beats a same-cycle step; flag sets beat same-cycle clears.
        if (wr_ctl && bus.wr_data[0]) count_d = '0;
        ovf_d      = (ovf_q      & ~(wr_ctl & bus.wr_data[2])) | ovf_set;
        btn_flag_d = (btn_flag_q & ~(wr_ctl & bus.wr_data[1])) | btn_rise;
        if (wr_cfg) sat_d = bus.wr_data[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            ovf_q      <= 1'b0;
            btn_flag_q <= 1'b0;
            dir_q      <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            btn_flag_q <= btn_flag_d;
            dir_q      <= dir_d;
            sat_q      <= sat_d;
        end
    end

    always_comb begin
        bus.rd_data = 32'h0;
        if (bus.addr[4:2] == 3'b000) begin
            case (bus.addr[1:0])
                2'd0:    bus.rd_data = {{(32-CNT_W){count_q[CNT_W-1]}}, count_q};
                2'd1:    bus.rd_data = {26'b0, ovf_q, btn_flag_q, dir_q, filt[3], filt[2], 1'b0};
                2'd3:    bus.rd_data = {31'b0, sat_q};
                default: bus.rd_data = 32'h0;
            endcase
        end
    end

    logic unused_sig;
    assign unused_sig = ^{bus.read, bus.wr_data[31:3]};
endmodule
